// File: rtl/syn_phase_lock_pkg.sv
// Shared framing definitions: state codes, default sync period and a
// saturating counter helper used by the sync-qualification logic.
package syn_phase_lock_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } state_t;

  localparam int DEF_PERIOD = 8;
  localparam int DEF_CW     = 3;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/syn_phase_lock_if.sv
// Sync-pulse input and phase/lock status outputs between the sync
// generator side (master) and the phase-lock block (slave).
interface syn_phase_lock_if #(
  parameter int CW = syn_phase_lock_pkg::DEF_CW
);
  logic          isyn;
  logic [CW-1:0] ophase;
  logic          ofrm;
  logic          olock;
  logic          oerr;
  logic [1:0]    ostate;

  modport master (
    output isyn,
    input  ophase, ofrm, olock, oerr, ostate
  );

  modport slave (
    input  isyn,
    output ophase, ofrm, olock, oerr, ostate
  );
endinterface

// File: rtl/syn_phase_lock.sv
// Qualifies the 38 MHz sync pulse with a hunt/presync/sync framer and keeps
// a flywheel phase counter running across missing or corrupted pulses.
module syn_phase_lock
  import syn_phase_lock_pkg::*;
#(
  parameter int PERIOD   = DEF_PERIOD,
  parameter int CW       = DEF_CW,
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2
) (
  input  logic         iclk38,
  input  logic         rst,
  syn_phase_lock_if.slave bus
);

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [3:0]    LOCK = 4'(LOCK_CNT);
  localparam logic [3:0]    LOSS = 4'(LOSS_CNT);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    good, good_n;
  logic [3:0]    miss, miss_n;
  logic          err, err_n;

  logic expected;
  logic bad;

  assign expected = (cnt == LAST);
  // In SYNC exactly one of these can be true per cycle, so at most one bad event counts.
  assign bad      = expected ? !bus.isyn : bus.isyn;

  always_comb begin
    state_n = state;
    cnt_n   = expected ? '0 : cnt + 1'b1;
    good_n  = good;
    miss_n  = miss;
    err_n   = 1'b0;
    case (state)
      HUNT: begin
        if (bus.isyn) begin
          cnt_n  = '0;
          good_n = 4'd1;
          if (LOCK == 4'd1) begin
            state_n = SYNC;
            miss_n  = 4'd0;
          end else begin
            state_n = PRESYNC;
          end
        end
      end
      PRESYNC: begin
        if (expected) begin
          if (bus.isyn) begin
            good_n = sat_inc(good);
            if (sat_inc(good) == LOCK) begin
              state_n = SYNC;
              miss_n  = 4'd0;
            end
          end else begin
            state_n = HUNT;
            good_n  = 4'd0;
          end
        end else if (bus.isyn) begin
          cnt_n  = '0;
          good_n = 4'd1;
        end
      end
      SYNC: begin
        // Flywheel: the counter is never realigned once locked.
        if (expected && bus.isyn) miss_n = 4'd0;
        if (bad) begin
          err_n  = 1'b1;
          miss_n = sat_inc(miss);
          if (sat_inc(miss) == LOSS) begin
            state_n = HUNT;
            good_n  = 4'd0;
            miss_n  = 4'd0;
          end
        end
      end
      default: begin
        state_n = HUNT;
        good_n  = 4'd0;
        miss_n  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge iclk38) begin
    if (rst) begin
      state <= HUNT;
      cnt   <= '0;
      good  <= 4'd0;
      miss  <= 4'd0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      good  <= good_n;
      miss  <= miss_n;
      err   <= err_n;
    end
  end

  assign bus.ophase = cnt;
  assign bus.olock  = (state == SYNC);
  assign bus.ofrm   = bus.olock && (cnt == '0);
  assign bus.oerr   = err;
  assign bus.ostate = state;

endmodule

// File: tb/tb_syn_phase_lock.sv
// Directed bench for syn_phase_lock (PERIOD=8, LOCK_CNT=3, LOSS_CNT=2):
// lock, flywheel miss, loss, PRESYNC realign, spurious pulse, reset.
module tb_syn_phase_lock;

  logic iclk38 = 1'b0;
  logic rst    = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  syn_phase_lock_if #(.CW(3)) bus ();

  syn_phase_lock #(
    .PERIOD(8), .CW(3), .LOCK_CNT(3), .LOSS_CNT(2)
  ) dut (
    .iclk38 (iclk38),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 iclk38 = ~iclk38;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive isyn for one cycle, then look at the registered result.
  task automatic cyc(input logic s);
    bus.isyn = s;
    @(posedge iclk38);
    #1;
  endtask

  // Seven quiet cycles, then a pulse on the expected slot.
  task automatic period_pulse();
    repeat (7) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic status(input string tag, input int ph, input int st,
                        input int lk, input int fr, input int er);
    chk({tag, ".phase"}, 8'(bus.ophase), 8'(ph));
    chk({tag, ".state"}, 8'(bus.ostate), 8'(st));
    chk({tag, ".lock"},  8'(bus.olock),  8'(lk));
    chk({tag, ".frm"},   8'(bus.ofrm),   8'(fr));
    chk({tag, ".err"},   8'(bus.oerr),   8'(er));
  endtask

  initial begin
    bus.isyn = 1'b0;

    // 1. Reset and lock
    rst = 1'b1;
    repeat (4) cyc(1'b0);
    status("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (3) cyc(1'b0);
    chk("hunt_freerun.phase", 8'(bus.ophase), 8'd3);
    cyc(1'b1);
    status("first_pulse", 0, 1, 0, 0, 0);
    period_pulse();
    status("second_pulse", 0, 1, 0, 0, 0);
    period_pulse();
    status("lock", 0, 2, 1, 1, 0);
    cyc(1'b0);
    status("lock_ph1", 1, 2, 1, 0, 0);
    repeat (6) cyc(1'b0);
    cyc(1'b1);
    status("lock_frm2", 0, 2, 1, 1, 0);

    // 2. Single miss, flywheel keeps going
    repeat (8) cyc(1'b0);
    status("miss1", 0, 2, 1, 1, 1);
    cyc(1'b0);
    status("miss1_after", 1, 2, 1, 0, 0);
    repeat (6) cyc(1'b0);
    cyc(1'b1);
    status("miss1_recover", 0, 2, 1, 1, 0);
    repeat (8) cyc(1'b0);
    status("miss_cleared", 0, 2, 1, 1, 1);
    period_pulse();
    status("miss_cleared_good", 0, 2, 1, 1, 0);

    // 3. Loss of lock after two consecutive misses
    repeat (8) cyc(1'b0);
    status("loss_bad1", 0, 2, 1, 1, 1);
    repeat (8) cyc(1'b0);
    status("loss_bad2", 0, 0, 0, 0, 1);
    cyc(1'b0);
    status("loss_after", 1, 0, 0, 0, 0);
    repeat (7) cyc(1'b0);
    status("loss_nofrm", 0, 0, 0, 0, 0);

    // 4. Phase jump in PRESYNC
    cyc(1'b1);
    status("p4_first", 0, 1, 0, 0, 0);
    period_pulse();
    status("p4_second", 0, 1, 0, 0, 0);
    repeat (2) cyc(1'b0);
    cyc(1'b1);
    status("p4_jump", 0, 1, 0, 0, 0);
    period_pulse();
    status("p4_good2", 0, 1, 0, 0, 0);
    period_pulse();
    status("p4_lock", 0, 2, 1, 1, 0);

    // 5. Spurious pulse in SYNC, no realign
    repeat (3) cyc(1'b0);
    chk("p5_pre.phase", 8'(bus.ophase), 8'd3);
    cyc(1'b1);
    status("p5_spur", 4, 2, 1, 0, 1);
    repeat (3) cyc(1'b0);
    chk("p5_ph7.phase", 8'(bus.ophase), 8'd7);
    cyc(1'b1);
    status("p5_on_sched", 0, 2, 1, 1, 0);

    // 6. Mid-operation reset at phase 5, pulse during reset ignored
    repeat (5) cyc(1'b0);
    chk("p6_pre.phase", 8'(bus.ophase), 8'd5);
    rst = 1'b1;
    cyc(1'b0);
    status("p6_rst", 0, 0, 0, 0, 0);
    cyc(1'b1);
    status("p6_rst_pulse", 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(1'b1);
    status("p6_relock1", 0, 1, 0, 0, 0);
    period_pulse();
    status("p6_relock2", 0, 1, 0, 0, 0);
    period_pulse();
    status("p6_relock3", 0, 2, 1, 1, 0);

    // isyn held high in SYNC: loss within two cycles
    cyc(1'b1);
    status("held1", 1, 2, 1, 0, 1);
    cyc(1'b1);
    status("held2", 2, 0, 0, 0, 1);
    cyc(1'b1);
    status("held3", 0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
